// File: rtl/etapa_decodificacion.sv
// Decode stage: skid FIFO from fetch, registered valid/ready bundle to execute,
// redirect/squash control and halt. Define ID_EARLY_JUMP_EN to resolve JUMP_OP in decode.
module etapa_decodificacion #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter logic [4:0]  HALT_OP       = 5'b01011,
    parameter logic [4:0]  JUMP_OP       = 5'b01000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instruccion,
    input  logic        fetch_valid,
    input  logic        ex_redirect,
    input  logic [6:0]  ex_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [4:0]  id_opcode,
    output logic [3:0]  id_rd,
    output logic [3:0]  id_rs1,
    output logic [3:0]  id_rs2,
    output logic [31:0] id_imm,
    output logic [6:0]  branchResultOut,
    output logic        halted,
    output logic        overflow_err,
    output logic [1:0]  o_state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(SQUASH_CYCLES + 2);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_sq_cnt;
    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [6:0]  r_branch;
    logic        r_halted;
    logic        r_ovf;

    logic        w_empty;
    logic        w_full;
    logic [31:0] w_head;
    logic        w_ex_redir;
    logic        w_pop;
    logic        w_jump_en;
    logic        w_jump;
    logic        w_halt;
    logic        w_flush;
    logic        w_push_req;
    logic        w_push;
    logic        w_ovf;

`ifdef ID_EARLY_JUMP_EN
    assign w_jump_en = 1'b1;
`else
    assign w_jump_en = 1'b0;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Handshake: a bundle transfers on any edge where id_valid & id_ready; the
    // output register holds while id_valid & ~id_ready and refills from the FIFO
    // head whenever it is empty or transferring.
    assign w_ex_redir = ex_redirect && (ex_target != 7'd0) && (r_state != ST_HALT);
    assign w_pop      = (r_state != ST_HALT) && !w_empty && (!r_valid || id_ready) && !w_ex_redir;
    assign w_jump     = w_jump_en && w_pop && (w_head[31:27] == JUMP_OP) && (w_head[6:0] != 7'd0);
    assign w_halt     = w_pop && (w_head[31:27] == HALT_OP);
    assign w_flush    = w_ex_redir || w_jump || w_halt;

    // A word arriving on a flush edge is wrong-path and is dropped without counting as overflow.
    assign w_push_req = (r_state == ST_RUN) && fetch_valid;
    assign w_push     = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_ovf      = w_push_req && !w_flush && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= Instruccion;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_sq_cnt <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_branch <= '0;
            r_halted <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_branch <= 7'd0;
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            if (w_ex_redir) begin
                r_valid <= 1'b0;
            end else if (w_pop) begin
                r_valid <= 1'b1;
                r_instr <= w_head;
            end else if (id_ready) begin
                r_valid <= 1'b0;
            end

            // Execute redirect outranks anything decode resolves on the same edge.
            if (w_ex_redir) begin
                r_branch <= ex_target;
                r_state  <= ST_SQUASH;
                r_sq_cnt <= CW'(SQUASH_CYCLES);
            end else if (w_jump) begin
                r_branch <= w_head[6:0];
                r_state  <= ST_SQUASH;
                r_sq_cnt <= CW'(SQUASH_CYCLES);
            end else if (w_halt) begin
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
            end else if ((r_state == ST_SQUASH) && fetch_valid) begin
                if (r_sq_cnt <= CW'(1)) begin
                    r_sq_cnt <= '0;
                    r_state  <= ST_RUN;
                end else begin
                    r_sq_cnt <= r_sq_cnt - CW'(1);
                end
            end
        end
    end

    assign id_valid        = r_valid;
    assign id_opcode       = r_instr[31:27];
    assign id_rd           = r_instr[26:23];
    assign id_rs1          = r_instr[22:19];
    assign id_rs2          = r_instr[18:15];
    assign id_imm          = {{13{r_instr[18]}}, r_instr[18:0]};
    assign branchResultOut = r_branch;
    assign halted          = r_halted;
    assign overflow_err    = r_ovf;
    assign o_state         = r_state;

endmodule
